// File: rtl/udp_pkg.sv
// -----------------------------------------------------------------------------
// udp_pkg
// Shared definitions for the UDP receive path: FSM state encoding, UDP header
// constants, the byte-enable encoding used on the 32-bit payload bus, and small
// helpers for ones-complement folding and byte masking.
// Used by udp_receiver and udp_chksum_acc (checksum build, UDP_RX_CHKSUM_EN).
// -----------------------------------------------------------------------------
package udp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR1 = 2'd1,
        DATA = 2'd2,
        DROP = 2'd3
    } udp_state_t;

    localparam logic [15:0] UDP_HDR_LEN = 16'd8;
    localparam logic [7:0]  UDP_PROTO   = 8'h11;

    // Byte-enable encoding: number of valid bytes, MSB-aligned, 0 means all 4.
    localparam logic [1:0] BE_4B = 2'b00;
    localparam logic [1:0] BE_1B = 2'b01;
    localparam logic [1:0] BE_2B = 2'b10;
    localparam logic [1:0] BE_3B = 2'b11;

    // Byte count (1..4) remaining in the final beat -> be code.
    function automatic logic [1:0] bytes_to_be(input logic [2:0] n);
        case (n)
            3'd1:    bytes_to_be = BE_1B;
            3'd2:    bytes_to_be = BE_2B;
            3'd3:    bytes_to_be = BE_3B;
            default: bytes_to_be = BE_4B;
        endcase
    endfunction

    // Keeps the valid MSB-aligned bytes of a beat, zeroes the rest.
    function automatic logic [31:0] be_mask(input logic [1:0] be);
        case (be)
            BE_1B:   be_mask = 32'hFF00_0000;
            BE_2B:   be_mask = 32'hFFFF_0000;
            BE_3B:   be_mask = 32'hFFFF_FF00;
            default: be_mask = 32'hFFFF_FFFF;
        endcase
    endfunction

    // Ones-complement fold of a 32-bit running sum. One fold leaves at most
    // 17 bits; adding that carry back cannot carry again.
    function automatic logic [15:0] ones_fold(input logic [31:0] x);
        logic [16:0] t;
        logic [16:0] t2;
        t         = {1'b0, x[31:16]} + {1'b0, x[15:0]};
        t2        = {1'b0, t[15:0]} + {16'b0, t[16]};
        ones_fold = t2[15:0];
    endfunction

endpackage

// File: rtl/udp_receiver_if.sv
// -----------------------------------------------------------------------------
// udp_receiver_if
// Payload stream bundle for the UDP receiver: the IP payload stream going in
// and the UDP payload stream coming out.
//   udp_data_in/udp_be_in/udp_data_in_val/udp_sop_in/udp_eop_in : IP payload
//   udp_data_out/udp_be_out/udp_data_out_val/udp_data_out_eop    : UDP payload
// modport master : source of the IP stream / sink of the UDP stream
// modport slave  : the receiver
// -----------------------------------------------------------------------------
interface udp_receiver_if;

    logic [31:0] udp_data_in;
    logic [1:0]  udp_be_in;
    logic        udp_data_in_val;
    logic        udp_sop_in;
    logic        udp_eop_in;

    logic [31:0] udp_data_out;
    logic [1:0]  udp_be_out;
    logic        udp_data_out_val;
    logic        udp_data_out_eop;

    modport master (
        output udp_data_in, udp_be_in, udp_data_in_val, udp_sop_in, udp_eop_in,
        input  udp_data_out, udp_be_out, udp_data_out_val, udp_data_out_eop
    );

    modport slave (
        input  udp_data_in, udp_be_in, udp_data_in_val, udp_sop_in, udp_eop_in,
        output udp_data_out, udp_be_out, udp_data_out_val, udp_data_out_eop
    );

endinterface

// File: rtl/udp_chksum_acc.sv
// -----------------------------------------------------------------------------
// udp_chksum_acc
// Running 16-bit ones-complement sum over 32-bit beats. Instantiated by
// udp_receiver only when UDP_RX_CHKSUM_EN is defined.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the sum (combined with add_en, the beat starts it)
//   add_en     : add this beat
//   data, be   : beat and its byte enable; invalid bytes are added as zero
//   result     : folded sum including the beat presented this cycle
// -----------------------------------------------------------------------------
module udp_chksum_acc
    import udp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        add_en,
    input  logic [31:0] data,
    input  logic [1:0]  be,
    output logic [15:0] result
);

    logic [31:0] acc_q;
    logic [31:0] acc_next;
    logic [31:0] masked;

    always_comb begin
        masked   = data & be_mask(be);
        acc_next = clear ? 32'd0 : acc_q;
        if (add_en) begin
            acc_next = acc_next + {16'd0, masked[31:16]} + {16'd0, masked[15:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 32'd0;
        end else begin
            acc_q <= acc_next;
        end
    end

    // Result looks through to acc_next so the decision on the final beat sees it.
    assign result = ones_fold(acc_next);

endmodule

// File: rtl/udp_receiver.sv
// -----------------------------------------------------------------------------
// udp_receiver
// Parses the 8-byte UDP header from a 32-bit IP payload stream, filters on the
// destination port and forwards the UDP payload with one cycle of latency.
// Optional checksum verification is built when UDP_RX_CHKSUM_EN is defined;
// without it the address inputs and the checksum field are ignored.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   udp_rx_port_filter  : accepted destination port, 0 accepts all
//   udp_ip_src_addr/dst : IP addresses for the pseudo-header (checksum build)
//   bus (slave)         : IP payload in, UDP payload out (udp_receiver_if)
//   udp_src_port/dst_port/data_length : header fields of current/last packet
//   udp_busy/done/err   : status
// -----------------------------------------------------------------------------
module udp_receiver
    import udp_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [15:0]    udp_rx_port_filter,
    input  logic [31:0]    udp_ip_src_addr,
    input  logic [31:0]    udp_ip_dst_addr,
    udp_receiver_if.slave  bus,
    output logic [15:0]    udp_src_port,
    output logic [15:0]    udp_dst_port,
    output logic [15:0]    udp_data_length,
    output logic           udp_busy,
    output logic           udp_done,
    output logic           udp_err
);

    udp_state_t  state_q;
    logic [15:0] remaining_q;
    logic [31:0] data_q;
    logic [1:0]  be_q;
    logic        val_q;
    logic        eop_q;
    logic        done_q;
    logic        err_q;

    logic        in_val;
    logic        in_sop;
    logic        in_eop;
    logic [31:0] in_data;
    logic [15:0] hdr_len;
    logic        last_beat;
    logic        port_mismatch;
    logic        chk_bad;

    assign in_val  = bus.udp_data_in_val;
    assign in_sop  = bus.udp_sop_in;
    assign in_eop  = bus.udp_eop_in;
    assign in_data = bus.udp_data_in;
    assign hdr_len = in_data[31:16];

    assign last_beat     = (remaining_q <= 16'd4);
    assign port_mismatch = (udp_rx_port_filter != 16'd0) &&
                           (udp_dst_port != udp_rx_port_filter);

`ifdef UDP_RX_CHKSUM_EN
    logic [15:0] chk_rx_q;
    logic [15:0] udp_len_q;
    logic [15:0] chk_cur;
    logic [15:0] len_cur;
    logic [15:0] acc_result;
    logic [31:0] pseudo_sum;
    logic [15:0] chk_final;
    logic        acc_clear;
    logic        acc_add;
    logic [1:0]  acc_be;

    // Header word 1 is latched on the same edge that may decide done, so
    // look through to the incoming value while in HDR1.
    assign chk_cur = (state_q == HDR1) ? in_data[15:0] : chk_rx_q;
    assign len_cur = (state_q == HDR1) ? hdr_len : udp_len_q;

    always_comb begin
        acc_clear = in_val && in_sop;
        acc_add   = in_val && (in_sop || state_q == HDR1 || state_q == DATA);
        acc_be    = BE_4B;
        if (in_val && !in_sop && state_q == DATA && last_beat) begin
            acc_be = bytes_to_be(remaining_q[2:0]);
        end
    end

    udp_chksum_acc u_chksum_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (acc_clear),
        .add_en (acc_add),
        .data   (in_data),
        .be     (acc_be),
        .result (acc_result)
    );

    assign pseudo_sum = {16'd0, udp_ip_src_addr[31:16]} + {16'd0, udp_ip_src_addr[15:0]} +
                        {16'd0, udp_ip_dst_addr[31:16]} + {16'd0, udp_ip_dst_addr[15:0]} +
                        {24'd0, UDP_PROTO} + {16'd0, len_cur} + {16'd0, acc_result};
    assign chk_final  = ones_fold(pseudo_sum);
    // A zero checksum field means the sender did not compute one.
    assign chk_bad    = (chk_cur != 16'd0) && (chk_final != 16'hFFFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_rx_q  <= 16'd0;
            udp_len_q <= 16'd0;
        end else if (in_val && !in_sop && state_q == HDR1) begin
            chk_rx_q  <= in_data[15:0];
            udp_len_q <= hdr_len;
        end
    end
`else
    logic unused_addr;
    assign unused_addr = ^{udp_ip_src_addr, udp_ip_dst_addr};
    assign chk_bad     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            remaining_q     <= 16'd0;
            data_q          <= 32'd0;
            be_q            <= BE_4B;
            val_q           <= 1'b0;
            eop_q           <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            udp_src_port    <= 16'd0;
            udp_dst_port    <= 16'd0;
            udp_data_length <= 16'd0;
        end else begin
            val_q  <= 1'b0;
            eop_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (in_val) begin
                if (in_sop) begin
                    // sop outside IDLE aborts the packet in flight and restarts here.
                    udp_src_port <= in_data[31:16];
                    udp_dst_port <= in_data[15:0];
                    err_q        <= (state_q != IDLE);
                    state_q      <= in_eop ? IDLE : HDR1;
                end else begin
                    unique case (state_q)
                        IDLE: begin
                            state_q <= IDLE;
                        end
                        HDR1: begin
                            if (hdr_len < UDP_HDR_LEN || port_mismatch) begin
                                state_q <= in_eop ? IDLE : DROP;
                            end else begin
                                udp_data_length <= hdr_len - UDP_HDR_LEN;
                                remaining_q     <= hdr_len - UDP_HDR_LEN;
                                if (hdr_len == UDP_HDR_LEN) begin
                                    done_q  <= 1'b1;
                                    err_q   <= chk_bad;
                                    state_q <= in_eop ? IDLE : DROP;
                                end else if (in_eop) begin
                                    err_q   <= 1'b1;
                                    state_q <= IDLE;
                                end else begin
                                    state_q <= DATA;
                                end
                            end
                        end
                        DATA: begin
                            val_q  <= 1'b1;
                            data_q <= in_data;
                            if (last_beat) begin
                                be_q        <= bytes_to_be(remaining_q[2:0]);
                                eop_q       <= 1'b1;
                                done_q      <= 1'b1;
                                err_q       <= chk_bad;
                                remaining_q <= 16'd0;
                                // Anything after the UDP length up to eop is IP padding.
                                state_q     <= in_eop ? IDLE : DROP;
                            end else begin
                                remaining_q <= remaining_q - 16'd4;
                                if (in_eop) begin
                                    // Truncated packet: pass the beat as-is and flag it.
                                    be_q    <= bus.udp_be_in;
                                    eop_q   <= 1'b1;
                                    err_q   <= 1'b1;
                                    state_q <= IDLE;
                                end else begin
                                    be_q    <= BE_4B;
                                end
                            end
                        end
                        DROP: begin
                            if (in_eop) begin
                                state_q <= IDLE;
                            end
                        end
                        default: begin
                            state_q <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign bus.udp_data_out     = data_q;
    assign bus.udp_be_out       = be_q;
    assign bus.udp_data_out_val = val_q;
    assign bus.udp_data_out_eop = eop_q;
    assign udp_busy             = (state_q != IDLE);
    assign udp_done             = done_q;
    assign udp_err              = err_q;

endmodule

// File: tb/tb_udp_receiver.sv
// -----------------------------------------------------------------------------
// tb_udp_receiver
// Directed bench for udp_receiver. Inputs change on the falling edge; outputs
// are checked on the following falling edge, after the registering edge.
// -----------------------------------------------------------------------------
module tb_udp_receiver;

    logic        clk;
    logic        rst_n;
    logic [15:0] udp_rx_port_filter;
    logic [31:0] udp_ip_src_addr;
    logic [31:0] udp_ip_dst_addr;
    logic [15:0] udp_src_port;
    logic [15:0] udp_dst_port;
    logic [15:0] udp_data_length;
    logic        udp_busy;
    logic        udp_done;
    logic        udp_err;

    int n_assert;
    int n_fail;

    udp_receiver_if bus_if ();

    udp_receiver dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .udp_rx_port_filter (udp_rx_port_filter),
        .udp_ip_src_addr    (udp_ip_src_addr),
        .udp_ip_dst_addr    (udp_ip_dst_addr),
        .bus                (bus_if),
        .udp_src_port       (udp_src_port),
        .udp_dst_port       (udp_dst_port),
        .udp_data_length    (udp_data_length),
        .udp_busy           (udp_busy),
        .udp_done           (udp_done),
        .udp_err            (udp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] be,
                        input logic sop, input logic eop);
        bus_if.udp_data_in     = d;
        bus_if.udp_be_in       = be;
        bus_if.udp_sop_in      = sop;
        bus_if.udp_eop_in      = eop;
        bus_if.udp_data_in_val = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle();
        bus_if.udp_data_in_val = 1'b0;
        bus_if.udp_sop_in      = 1'b0;
        bus_if.udp_eop_in      = 1'b0;
        @(negedge clk);
    endtask

    // Output stream snapshot: val, data, be, eop.
    task automatic check_out(input string tag, input logic val, input logic [31:0] d,
                             input logic [1:0] be, input logic eop);
        check({tag, "_val"}, {31'd0, bus_if.udp_data_out_val}, {31'd0, val});
        if (val) begin
            check({tag, "_data"}, bus_if.udp_data_out, d);
            check({tag, "_be"},   {30'd0, bus_if.udp_be_out}, {30'd0, be});
        end
        check({tag, "_eop"}, {31'd0, bus_if.udp_data_out_eop}, {31'd0, eop});
    endtask

    task automatic check_stat(input string tag, input logic busy, input logic done,
                              input logic err);
        check({tag, "_busy"}, {31'd0, udp_busy}, {31'd0, busy});
        check({tag, "_done"}, {31'd0, udp_done}, {31'd0, done});
        check({tag, "_err"},  {31'd0, udp_err},  {31'd0, err});
    endtask

`ifdef UDP_RX_CHKSUM_EN
    // Transmit checksum for header word 0, length, and two payload words
    // (second already zero-padded), over the IPv4 pseudo-header.
    function automatic logic [15:0] model_csum(input logic [31:0] sa, input logic [31:0] da,
                                               input logic [31:0] w0, input logic [15:0] len,
                                               input logic [31:0] p0, input logic [31:0] p1);
        logic [31:0] s;
        s = 32'(sa[31:16]) + 32'(sa[15:0]) + 32'(da[31:16]) + 32'(da[15:0]) +
            32'h0011 + 32'(len) + 32'(w0[31:16]) + 32'(w0[15:0]) + 32'(len) +
            32'(p0[31:16]) + 32'(p0[15:0]) + 32'(p1[31:16]) + 32'(p1[15:0]);
        s = 32'(s[31:16]) + 32'(s[15:0]);
        s = 32'(s[31:16]) + 32'(s[15:0]);
        return ~s[15:0];
    endfunction
`endif

    initial begin
`ifdef UDP_RX_CHKSUM_EN
        logic [15:0] csum;
`endif
        n_assert               = 0;
        n_fail                 = 0;
        rst_n                  = 1'b0;
        udp_rx_port_filter     = 16'h0000;
        udp_ip_src_addr        = 32'hC0A8_0001;
        udp_ip_dst_addr        = 32'hC0A8_000A;
        bus_if.udp_data_in     = 32'd0;
        bus_if.udp_be_in       = 2'b00;
        bus_if.udp_data_in_val = 1'b0;
        bus_if.udp_sop_in      = 1'b0;
        bus_if.udp_eop_in      = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check_out("rst", 1'b0, 32'd0, 2'b00, 1'b0);
        check("rst_data", bus_if.udp_data_out, 32'd0);
        check_stat("rst", 1'b0, 1'b0, 1'b0);
        check("rst_src", {16'd0, udp_src_port}, 32'd0);
        check("rst_len", {16'd0, udp_data_length}, 32'd0);
        rst_n = 1'b1;
        idle();

        // Non-sop beat after reset is ignored, eop in IDLE is ignored
        beat(32'h0010_0000, 2'b00, 1'b0, 1'b0);
        check_stat("nosop", 1'b0, 1'b0, 1'b0);
        beat(32'hFFFF_FFFF, 2'b00, 1'b0, 1'b1);
        check_stat("idle_eop", 1'b0, 1'b0, 1'b0);
        check_out("idle_eop", 1'b0, 32'd0, 2'b00, 1'b0);

        // Ports 1234->5678, length 16, two payload words
        beat(32'h04D2_162E, 2'b00, 1'b1, 1'b0);
        check_stat("p1_sop", 1'b1, 1'b0, 1'b0);
        check("p1_src", {16'd0, udp_src_port}, 32'd1234);
        check("p1_dst", {16'd0, udp_dst_port}, 32'd5678);
        beat(32'h0010_0000, 2'b00, 1'b0, 1'b0);
        check("p1_len", {16'd0, udp_data_length}, 32'd8);
        check_out("p1_hdr", 1'b0, 32'd0, 2'b00, 1'b0);
        // val low mid-packet is a hold, not a beat
        idle();
        check_out("p1_gap", 1'b0, 32'd0, 2'b00, 1'b0);
        check_stat("p1_gap", 1'b1, 1'b0, 1'b0);
        beat(32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0);
        check_out("p1_b0", 1'b1, 32'hDEAD_BEEF, 2'b00, 1'b0);
        check_stat("p1_b0", 1'b1, 1'b0, 1'b0);
        beat(32'h0123_4567, 2'b00, 1'b0, 1'b1);
        check_out("p1_b1", 1'b1, 32'h0123_4567, 2'b00, 1'b1);
        check_stat("p1_b1", 1'b0, 1'b1, 1'b0);
        idle();
        check_out("p1_after", 1'b0, 32'd0, 2'b00, 1'b0);
        check("p1_done_clr", {31'd0, udp_done}, 32'd0);

        // Length 13: five payload bytes, then one padding beat
        beat(32'h0001_0002, 2'b00, 1'b1, 1'b0);
        beat(32'h000D_0000, 2'b00, 1'b0, 1'b0);
        check("p2_len", {16'd0, udp_data_length}, 32'd5);
        beat(32'h1122_3344, 2'b00, 1'b0, 1'b0);
        check_out("p2_b0", 1'b1, 32'h1122_3344, 2'b00, 1'b0);
        beat(32'h5500_0000, 2'b00, 1'b0, 1'b0);
        check_out("p2_b1", 1'b1, 32'h5500_0000, 2'b01, 1'b1);
        check_stat("p2_b1", 1'b1, 1'b1, 1'b0);
        beat(32'hAAAA_AAAA, 2'b00, 1'b0, 1'b1);
        check_out("p2_pad", 1'b0, 32'd0, 2'b00, 1'b0);
        check_stat("p2_pad", 1'b0, 1'b0, 1'b0);

        // Filter 0x5678, packet dst 0x9999: dropped silently
        udp_rx_port_filter = 16'h5678;
        beat(32'h04D2_9999, 2'b00, 1'b1, 1'b0);
        beat(32'h000C_0000, 2'b00, 1'b0, 1'b0);
        check_stat("p3_hdr", 1'b1, 1'b0, 1'b0);
        beat(32'h1234_5678, 2'b00, 1'b0, 1'b0);
        check_out("p3_b0", 1'b0, 32'd0, 2'b00, 1'b0);
        check_stat("p3_b0", 1'b1, 1'b0, 1'b0);
        beat(32'h8765_4321, 2'b00, 1'b0, 1'b1);
        check_out("p3_eop", 1'b0, 32'd0, 2'b00, 1'b0);
        check_stat("p3_eop", 1'b0, 1'b0, 1'b0);

        // Matching filter passes
        beat(32'h04D2_5678, 2'b00, 1'b1, 1'b0);
        beat(32'h000C_0000, 2'b00, 1'b0, 1'b0);
        beat(32'hCAFE_F00D, 2'b00, 1'b0, 1'b1);
        check_out("p4_b0", 1'b1, 32'hCAFE_F00D, 2'b00, 1'b1);
        check_stat("p4_b0", 1'b0, 1'b1, 1'b0);
        udp_rx_port_filter = 16'h0000;

        // Length below header size is dropped
        beat(32'h0003_0004, 2'b00, 1'b1, 1'b0);
        beat(32'h0004_0000, 2'b00, 1'b0, 1'b0);
        check_stat("short_hdr", 1'b1, 1'b0, 1'b0);
        beat(32'h0000_0000, 2'b00, 1'b0, 1'b1);
        check_stat("short_eop", 1'b0, 1'b0, 1'b0);

        // Length 20 but eop after the 2nd payload word
        beat(32'h0005_0006, 2'b00, 1'b1, 1'b0);
        beat(32'h0014_0000, 2'b00, 1'b0, 1'b0);
        beat(32'hA0A0_A0A0, 2'b00, 1'b0, 1'b0);
        check_out("p5_b0", 1'b1, 32'hA0A0_A0A0, 2'b00, 1'b0);
        beat(32'hB0B0_B0B0, 2'b00, 1'b0, 1'b1);
        check_out("p5_b1", 1'b1, 32'hB0B0_B0B0, 2'b00, 1'b1);
        check_stat("p5_b1", 1'b0, 1'b0, 1'b1);
        idle();
        check("p5_err_clr", {31'd0, udp_err}, 32'd0);

        // sop mid-packet aborts and restarts; new packet has length 8
        beat(32'h0007_0008, 2'b00, 1'b1, 1'b0);
        beat(32'h0010_0000, 2'b00, 1'b0, 1'b0);
        beat(32'h1111_1111, 2'b00, 1'b0, 1'b0);
        beat(32'h0009_000A, 2'b00, 1'b1, 1'b0);
        check_stat("p6_abort", 1'b1, 1'b0, 1'b1);
        check_out("p6_abort", 1'b0, 32'd0, 2'b00, 1'b0);
        check("p6_src", {16'd0, udp_src_port}, 32'd9);
        beat(32'h0008_0000, 2'b00, 1'b0, 1'b1);
        check_stat("p6_len8", 1'b0, 1'b1, 1'b0);
        check_out("p6_len8", 1'b0, 32'd0, 2'b00, 1'b0);
        check("p6_len", {16'd0, udp_data_length}, 32'd0);

        // Reset mid-DATA clears everything at once
        beat(32'h04D2_162E, 2'b00, 1'b1, 1'b0);
        beat(32'h0010_0000, 2'b00, 1'b0, 1'b0);
        beat(32'h5A5A_5A5A, 2'b00, 1'b0, 1'b0);
        check_out("p7_b0", 1'b1, 32'h5A5A_5A5A, 2'b00, 1'b0);
        bus_if.udp_data_in_val = 1'b0;
        rst_n = 1'b0;
        #1;
        check_out("p7_rst", 1'b0, 32'd0, 2'b00, 1'b0);
        check("p7_rst_data", bus_if.udp_data_out, 32'd0);
        check_stat("p7_rst", 1'b0, 1'b0, 1'b0);
        check("p7_rst_dst", {16'd0, udp_dst_port}, 32'd0);
        check("p7_rst_len", {16'd0, udp_data_length}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        // Leftover payload of the old packet must not be parsed as a header
        beat(32'h0010_0000, 2'b00, 1'b0, 1'b1);
        check_stat("p8_stale", 1'b0, 1'b0, 1'b0);
        beat(32'h0064_00C8, 2'b00, 1'b1, 1'b0);
        beat(32'h000E_0000, 2'b00, 1'b0, 1'b0);
        check("p8_src", {16'd0, udp_src_port}, 32'd100);
        check("p8_dst", {16'd0, udp_dst_port}, 32'd200);
        check("p8_len", {16'd0, udp_data_length}, 32'd6);
        beat(32'h0102_0304, 2'b00, 1'b0, 1'b0);
        check_out("p8_b0", 1'b1, 32'h0102_0304, 2'b00, 1'b0);
        beat(32'h0506_0000, 2'b00, 1'b0, 1'b1);
        check_out("p8_b1", 1'b1, 32'h0506_0000, 2'b10, 1'b1);
        check_stat("p8_b1", 1'b0, 1'b1, 1'b0);
        idle();

`ifdef UDP_RX_CHKSUM_EN
        // Checksum over header, length 13 payload (last byte 0x55, rest padding)
        csum = model_csum(udp_ip_src_addr, udp_ip_dst_addr, 32'h04D2_162E, 16'd13,
                          32'h1122_3344, 32'h5500_0000);
        beat(32'h04D2_162E, 2'b00, 1'b1, 1'b0);
        beat({16'd13, csum}, 2'b00, 1'b0, 1'b0);
        beat(32'h1122_3344, 2'b00, 1'b0, 1'b0);
        beat(32'h55AA_BBCC, 2'b00, 1'b0, 1'b1);
        check_stat("ck_good", 1'b0, 1'b1, 1'b0);
        idle();
        beat(32'h04D2_162E, 2'b00, 1'b1, 1'b0);
        beat({16'd13, csum}, 2'b00, 1'b0, 1'b0);
        beat(32'h1122_3345, 2'b00, 1'b0, 1'b0);
        beat(32'h5500_0000, 2'b00, 1'b0, 1'b1);
        check_stat("ck_flip", 1'b0, 1'b1, 1'b1);
        idle();
        beat(32'h04D2_162E, 2'b00, 1'b1, 1'b0);
        beat(32'h000D_0000, 2'b00, 1'b0, 1'b0);
        beat(32'h1122_3345, 2'b00, 1'b0, 1'b0);
        beat(32'h5500_0000, 2'b00, 1'b0, 1'b1);
        check_stat("ck_zero", 1'b0, 1'b1, 1'b0);
        idle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
